// File: rtl/id_scoreboard.sv
// id_scoreboard: per-hart GPR pending-write scoreboard for the ID stage.
// Tracks which destination registers each hart still has in flight, picks
// an EX/MEM forwarding source for the two ID operands, and raises a stall
// for load-use and long-latency producers.
// Ports:
//   clk, reset (async, active-low)
//   ID  : id_valid, id_hart_id, rs1_addr, rs2_addr, src_reg_used, rd_addr,
//         gpr_we_ (active-low), id_issue
//   EX  : ex_en, ex_hart_id, ex_rd_addr, ex_gpr_we_, ex_is_load
//   MEM : mem_en, mem_hart_id, mem_rd_addr, mem_gpr_we_
//   WB  : wb_en, wb_hart_id, wb_rd_addr, wb_gpr_we_
//   kill: hkill, hkill_id
//   out : rs1_fwd_ctrl, rs2_fwd_ctrl, hazard_stall (combinational),
//         pend_any, stall_cnt (registered)
module id_scoreboard #(
  parameter int unsigned HART_NUM = 4,
  parameter int unsigned HART_W   = 2,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [HART_W-1:0]   id_hart_id,
  input  logic [REG_W-1:0]    rs1_addr,
  input  logic [REG_W-1:0]    rs2_addr,
  input  logic [1:0]          src_reg_used,
  input  logic [REG_W-1:0]    rd_addr,
  input  logic                gpr_we_,
  input  logic                id_issue,
  input  logic                ex_en,
  input  logic                mem_en,
  input  logic [HART_W-1:0]   ex_hart_id,
  input  logic [HART_W-1:0]   mem_hart_id,
  input  logic [REG_W-1:0]    ex_rd_addr,
  input  logic [REG_W-1:0]    mem_rd_addr,
  input  logic                ex_gpr_we_,
  input  logic                mem_gpr_we_,
  input  logic                ex_is_load,
  input  logic                wb_en,
  input  logic [HART_W-1:0]   wb_hart_id,
  input  logic [REG_W-1:0]    wb_rd_addr,
  input  logic                wb_gpr_we_,
  input  logic                hkill,
  input  logic [HART_W-1:0]   hkill_id,
  output logic [1:0]          rs1_fwd_ctrl,
  output logic [1:0]          rs2_fwd_ctrl,
  output logic                hazard_stall,
  output logic [HART_NUM-1:0] pend_any,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int unsigned REG_NUM = 1 << REG_W;
  localparam logic [1:0]  FWD_NONE = 2'b00;
  localparam logic [1:0]  FWD_EX   = 2'b01;
  localparam logic [1:0]  FWD_MEM  = 2'b10;

  logic [HART_NUM-1:0][REG_NUM-1:0] pend_q;
  logic [HART_NUM-1:0][REG_NUM-1:0] pend_d;
  logic [REG_NUM-1:0]               id_row;
  logic [1:0][REG_W-1:0]            src_addr;
  logic                             ex_prod;
  logic                             mem_prod;
  logic [1:0]                       src_live;
  logic [1:0]                       ex_hit;
  logic [1:0]                       mem_hit;
  logic [1:0]                       src_stall;
  logic                             set_en;
  logic                             clr_en;

  assign id_row   = pend_q[id_hart_id];
  assign src_addr = {rs2_addr, rs1_addr};

  // EX/MEM hold a GPR write belonging to the hart currently in ID
  assign ex_prod  = ex_en  && !ex_gpr_we_  && (ex_hart_id  == id_hart_id);
  assign mem_prod = mem_en && !mem_gpr_we_ && (mem_hart_id == id_hart_id);

  // Per-operand match and hazard; reset masks everything so outputs sit idle
  always_comb begin
    src_live  = '0;
    ex_hit    = '0;
    mem_hit   = '0;
    src_stall = '0;
    for (int i = 0; i < 2; i++) begin
      src_live[i] = reset && id_valid && src_reg_used[i] && (src_addr[i] != '0);
      ex_hit[i]   = src_live[i] && ex_prod  && (ex_rd_addr  == src_addr[i]);
      mem_hit[i]  = src_live[i] && mem_prod && (mem_rd_addr == src_addr[i]);
      src_stall[i] = (ex_hit[i] && ex_is_load) ||
                     (src_live[i] && id_row[src_addr[i]] && !ex_hit[i] && !mem_hit[i]);
    end
  end

  // Forwarding select: EX beats MEM
  always_comb begin
    rs1_fwd_ctrl = FWD_NONE;
    rs2_fwd_ctrl = FWD_NONE;
    if (ex_hit[0])       rs1_fwd_ctrl = FWD_EX;
    else if (mem_hit[0]) rs1_fwd_ctrl = FWD_MEM;
    if (ex_hit[1])       rs2_fwd_ctrl = FWD_EX;
    else if (mem_hit[1]) rs2_fwd_ctrl = FWD_MEM;
  end

  assign hazard_stall = |src_stall;

  // An issue that coincides with a stall is not accepted, so it sets nothing
  assign set_en = id_issue && id_valid && !gpr_we_ && (rd_addr != '0) && !hazard_stall;
  assign clr_en = wb_en && !wb_gpr_we_;

  // Table next state: WB clear, then issue set (set wins), then hart kill
  always_comb begin
    pend_d = pend_q;
    if (clr_en) pend_d[wb_hart_id][wb_rd_addr] = 1'b0;
    if (set_en) pend_d[id_hart_id][rd_addr] = 1'b1;
    if (hkill)  pend_d[hkill_id] = '0;
    for (int h = 0; h < HART_NUM; h++) pend_d[h][0] = 1'b0;
  end

  // Pending table
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  // Per-hart summary, one cycle behind the table
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_any <= '0;
    end else begin
      for (int h = 0; h < HART_NUM; h++) pend_any[h] <= |pend_q[h];
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (hazard_stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: directed stimulus against id_scoreboard with a
// behavioural reference model checked every negative clock edge, plus
// hand-computed expectations at the interesting points.
module tb_id_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, gpr_we_, id_issue;
  logic [1:0] id_hart_id, src_reg_used;
  logic [4:0] rs1_addr, rs2_addr, rd_addr;
  logic       ex_en, mem_en, ex_gpr_we_, mem_gpr_we_, ex_is_load;
  logic [1:0] ex_hart_id, mem_hart_id;
  logic [4:0] ex_rd_addr, mem_rd_addr;
  logic       wb_en, wb_gpr_we_;
  logic [1:0] wb_hart_id;
  logic [4:0] wb_rd_addr;
  logic       hkill;
  logic [1:0] hkill_id;

  logic [1:0]  rs1_fwd_ctrl, rs2_fwd_ctrl;
  logic        hazard_stall;
  logic [3:0]  pend_any;
  logic [15:0] stall_cnt;
  logic [1:0]  rs1_fwd_4, rs2_fwd_4;
  logic        hazard_4;
  logic [3:0]  pend_any_4;
  logic [3:0]  stall_cnt_4;

  always #5 clk = ~clk;

  id_scoreboard dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_hart_id(id_hart_id), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .src_reg_used(src_reg_used), .rd_addr(rd_addr), .gpr_we_(gpr_we_), .id_issue(id_issue),
    .ex_en(ex_en), .mem_en(mem_en), .ex_hart_id(ex_hart_id), .mem_hart_id(mem_hart_id),
    .ex_rd_addr(ex_rd_addr), .mem_rd_addr(mem_rd_addr), .ex_gpr_we_(ex_gpr_we_),
    .mem_gpr_we_(mem_gpr_we_), .ex_is_load(ex_is_load),
    .wb_en(wb_en), .wb_hart_id(wb_hart_id), .wb_rd_addr(wb_rd_addr), .wb_gpr_we_(wb_gpr_we_),
    .hkill(hkill), .hkill_id(hkill_id),
    .rs1_fwd_ctrl(rs1_fwd_ctrl), .rs2_fwd_ctrl(rs2_fwd_ctrl), .hazard_stall(hazard_stall),
    .pend_any(pend_any), .stall_cnt(stall_cnt)
  );

  id_scoreboard #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_hart_id(id_hart_id), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .src_reg_used(src_reg_used), .rd_addr(rd_addr), .gpr_we_(gpr_we_), .id_issue(id_issue),
    .ex_en(ex_en), .mem_en(mem_en), .ex_hart_id(ex_hart_id), .mem_hart_id(mem_hart_id),
    .ex_rd_addr(ex_rd_addr), .mem_rd_addr(mem_rd_addr), .ex_gpr_we_(ex_gpr_we_),
    .mem_gpr_we_(mem_gpr_we_), .ex_is_load(ex_is_load),
    .wb_en(wb_en), .wb_hart_id(wb_hart_id), .wb_rd_addr(wb_rd_addr), .wb_gpr_we_(wb_gpr_we_),
    .hkill(hkill), .hkill_id(hkill_id),
    .rs1_fwd_ctrl(rs1_fwd_4), .rs2_fwd_ctrl(rs2_fwd_4), .hazard_stall(hazard_4),
    .pend_any(pend_any_4), .stall_cnt(stall_cnt_4)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: which registers each hart is still waiting on
  bit [31:0] m_pend [4];
  bit [3:0]  m_pany;
  int        m_cnt;
  int        m_cnt4;

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs, input logic use_bit);
    if (!reset || !id_valid || !use_bit || rs == 5'd0) return 2'b00;
    if (ex_en && !ex_gpr_we_ && ex_hart_id == id_hart_id && ex_rd_addr == rs) return 2'b01;
    if (mem_en && !mem_gpr_we_ && mem_hart_id == id_hart_id && mem_rd_addr == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic src_blocks(input logic [4:0] rs, input logic use_bit);
    logic [1:0] f;
    f = exp_fwd(rs, use_bit);
    if (!reset || !id_valid || !use_bit || rs == 5'd0) return 1'b0;
    if (f == 2'b01) return ex_is_load;
    if (f == 2'b10) return 1'b0;
    return m_pend[id_hart_id][rs];
  endfunction

  function automatic logic exp_stall();
    return src_blocks(rs1_addr, src_reg_used[0]) || src_blocks(rs2_addr, src_reg_used[1]);
  endfunction

  always @(posedge clk or negedge reset) begin : model
    bit [31:0] nxt [4];
    bit [3:0]  npany;
    logic      st;
    if (!reset) begin
      for (int h = 0; h < 4; h++) m_pend[h] <= 32'd0;
      m_pany <= 4'd0;
      m_cnt  <= 0;
      m_cnt4 <= 0;
    end else begin
      st  = exp_stall();
      nxt = m_pend;
      for (int h = 0; h < 4; h++) npany[h] = (m_pend[h] != 32'd0);
      if (wb_en && !wb_gpr_we_) nxt[wb_hart_id][wb_rd_addr] = 1'b0;
      if (id_issue && id_valid && !gpr_we_ && rd_addr != 5'd0 && !st)
        nxt[id_hart_id][rd_addr] = 1'b1;
      if (hkill) nxt[hkill_id] = 32'd0;
      m_pend <= nxt;
      m_pany <= npany;
      if (st && m_cnt < 65535) m_cnt <= m_cnt + 1;
      if (st && m_cnt4 < 15)   m_cnt4 <= m_cnt4 + 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("rs1_fwd",    32'(rs1_fwd_ctrl), 32'(exp_fwd(rs1_addr, src_reg_used[0])));
      chk("rs2_fwd",    32'(rs2_fwd_ctrl), 32'(exp_fwd(rs2_addr, src_reg_used[1])));
      chk("stall",      32'(hazard_stall), 32'(exp_stall()));
      chk("pend_any",   32'(pend_any),     32'(m_pany));
      chk("stall_cnt",  32'(stall_cnt),    32'(m_cnt));
      chk("stall_cnt4", 32'(stall_cnt_4),  32'(m_cnt4));
    end
  end

  task automatic idle();
    id_valid = 0; id_hart_id = 0; rs1_addr = 0; rs2_addr = 0; src_reg_used = 0;
    rd_addr = 0; gpr_we_ = 1; id_issue = 0;
    ex_en = 0; ex_hart_id = 0; ex_rd_addr = 0; ex_gpr_we_ = 1; ex_is_load = 0;
    mem_en = 0; mem_hart_id = 0; mem_rd_addr = 0; mem_gpr_we_ = 1;
    wb_en = 0; wb_hart_id = 0; wb_rd_addr = 0; wb_gpr_we_ = 1;
    hkill = 0; hkill_id = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] h, input logic [4:0] rd);
    id_valid = 1; id_hart_id = h; rd_addr = rd; gpr_we_ = 0; id_issue = 1; src_reg_used = 2'b00;
  endtask

  task automatic rd_src(input logic [1:0] h, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [1:0] used);
    id_valid = 1; id_hart_id = h; rs1_addr = r1; rs2_addr = r2; src_reg_used = used; id_issue = 0;
  endtask

  task automatic ex_set(input logic [1:0] h, input logic [4:0] rd, input logic ld);
    ex_en = 1; ex_hart_id = h; ex_rd_addr = rd; ex_gpr_we_ = 0; ex_is_load = ld;
  endtask

  task automatic wb_set(input logic [1:0] h, input logic [4:0] rd);
    wb_en = 1; wb_hart_id = h; wb_rd_addr = rd; wb_gpr_we_ = 0;
  endtask

  initial begin
    reset = 0;
    idle();
    run_cmp = 1;
    // In reset with a load-use pattern presented: outputs must stay idle
    rd_src(1, 5, 0, 2'b01); ex_set(1, 5, 1);
    #2;
    chk("rst_stall",    32'(hazard_stall), 32'd0);
    chk("rst_fwd",      32'(rs1_fwd_ctrl), 32'd0);
    chk("rst_pend_any", 32'(pend_any),     32'd0);
    chk("rst_cnt",      32'(stall_cnt),    32'd0);
    cyc(); cyc();
    idle(); reset = 1;
    cyc(); cyc();

    // Issue hart1 rd5, then EX forwards it to rs1
    issue(1, 5);
    cyc(); idle(); rd_src(1, 5, 0, 2'b01); ex_set(1, 5, 0);
    #2 chk("ex_fwd_rs1", 32'(rs1_fwd_ctrl), 32'd1);
    chk("ex_fwd_nostall", 32'(hazard_stall), 32'd0);
    chk("pend_any_lag", 32'(pend_any), 32'd0);
    cyc(); idle(); wb_set(1, 5);
    #2 chk("pend_any_h1", 32'(pend_any), 32'h2);
    cyc(); idle(); cyc(); cyc();

    // Load-use with MEM also matching: stall for three cycles
    rd_src(1, 5, 0, 2'b01); ex_set(1, 5, 1);
    mem_en = 1; mem_hart_id = 1; mem_rd_addr = 5; mem_gpr_we_ = 0;
    #2 chk("lu_stall", 32'(hazard_stall), 32'd1);
    chk("lu_cnt0", 32'(stall_cnt), 32'd0);
    cyc(); cyc(); cyc();
    ex_is_load = 0;
    #2 chk("lu_cnt3", 32'(stall_cnt), 32'd3);
    chk("ex_over_mem", 32'(rs1_fwd_ctrl), 32'd1);
    chk("ex_over_mem_nostall", 32'(hazard_stall), 32'd0);
    cyc(); ex_en = 0;
    #2 chk("mem_fwd", 32'(rs1_fwd_ctrl), 32'd2);

    // Long-latency producer hart2 rd7 read as rs2 until WB
    cyc(); idle(); issue(2, 7);
    cyc(); idle(); rd_src(2, 0, 7, 2'b10); id_issue = 1; rd_addr = 9; gpr_we_ = 0;
    #2 chk("ll_stall", 32'(hazard_stall), 32'd1);
    cyc();
    #2 chk("ll_pend_any2", 32'(pend_any[2]), 32'd1);
    cyc(); id_issue = 0; wb_set(2, 7);
    #2 chk("ll_stall_wb", 32'(hazard_stall), 32'd1);
    cyc(); wb_en = 0; wb_gpr_we_ = 1;
    #2 chk("ll_release", 32'(hazard_stall), 32'd0);
    cyc(); rd_src(2, 9, 0, 2'b01);
    #2 chk("ll_pend_any2_clr", 32'(pend_any[2]), 32'd0);
    chk("stalled_issue_dropped", 32'(hazard_stall), 32'd0);

    // Same-cycle set and clear of hart0 rd3: set wins
    cyc(); idle(); issue(0, 3); wb_set(0, 3);
    cyc(); idle(); rd_src(0, 3, 0, 2'b01);
    #2 chk("set_wins", 32'(hazard_stall), 32'd1);
    cyc(); idle(); wb_set(0, 3);
    cyc(); idle(); issue(0, 0);
    cyc(); idle(); rd_src(0, 0, 0, 2'b01); ex_set(0, 0, 1);
    #2 chk("rd0_nostall", 32'(hazard_stall), 32'd0);
    chk("rd0_fwd", 32'(rs1_fwd_ctrl), 32'd0);
    cyc(); idle(); rd_src(0, 4, 0, 2'b01); ex_set(1, 4, 1);
    #2 chk("other_hart_fwd", 32'(rs1_fwd_ctrl), 32'd0);
    chk("other_hart_nostall", 32'(hazard_stall), 32'd0);

    // Hart 3 kill with a same-cycle hart-3 issue; hart 0 keeps its bit
    for (int r = 1; r <= 4; r++) begin
      cyc(); idle(); issue(3, 5'(r));
    end
    cyc(); idle(); issue(0, 6);
    cyc(); idle(); issue(3, 10); hkill = 1; hkill_id = 3;
    cyc(); idle();
    #2 chk("kill_pend_before", 32'(pend_any), 32'h9);
    cyc();
    #2 chk("kill_pend_after", 32'(pend_any), 32'h1);
    cyc(); rd_src(3, 10, 2, 2'b11);
    #2 chk("kill_no_set", 32'(hazard_stall), 32'd0);

    // 20 stall cycles saturate the 4-bit counter, then reset mid-stall
    cyc(); idle(); rd_src(0, 12, 0, 2'b01); ex_set(0, 12, 1);
    repeat (20) cyc();
    #1 chk("cnt4_sat", 32'(stall_cnt_4), 32'hF);
    #1 reset = 0;
    #1;
    chk("async_rst_stall",  32'(hazard_stall), 32'd0);
    chk("async_rst_fwd",    32'(rs1_fwd_ctrl), 32'd0);
    chk("async_rst_pend",   32'(pend_any),     32'd0);
    chk("async_rst_cnt",    32'(stall_cnt),    32'd0);
    chk("async_rst_cnt4",   32'(stall_cnt_4),  32'd0);
    cyc(); idle(); reset = 1; rd_src(0, 6, 0, 2'b01);
    #2 chk("rst_table_clear", 32'(hazard_stall), 32'd0);
    cyc(); cyc();
    #2 chk("rst_pend_any_stay", 32'(pend_any), 32'd0);
    chk("rst_cnt_stay", 32'(stall_cnt), 32'd0);
    cyc();

    run_cmp = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
ID_SCOREBOARD -- requirements
Module: id_scoreboard

Interface
REQ-001 SHALL take parameters: HART_NUM, default 4, number of hardware threads; HART_W, default 2, hart-id width; REG_W, default 5, GPR address width; CNT_W, default 16, stall-counter width.
REQ-002 SHALL have ports: clk  in  1  clock; reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ID inputs: id_valid in 1, instruction present; id_hart_id in HART_W; rs1_addr, rs2_addr in REG_W; src_reg_used in 2, bit0 = rs1 read, bit1 = rs2 read; rd_addr in REG_W; gpr_we_ in 1, active-low; id_issue in 1, instruction accepted into EX this cycle.
REQ-004 SHALL have EX/MEM snoop inputs: ex_en, mem_en in 1; ex_hart_id, mem_hart_id in HART_W; ex_rd_addr, mem_rd_addr in REG_W; ex_gpr_we_, mem_gpr_we_ in 1, active-low; ex_is_load in 1.
REQ-005 SHALL have WB inputs: wb_en in 1; wb_hart_id in HART_W; wb_rd_addr in REG_W; wb_gpr_we_ in 1, active-low.
REQ-006 SHALL have kill inputs: hkill in 1; hkill_id in HART_W, hart whose pending state is discarded.
REQ-007 SHALL have outputs: rs1_fwd_ctrl, rs2_fwd_ctrl out 2, 00 = NONE, 01 = EX, 10 = MEM; hazard_stall out 1; pend_any out HART_NUM, per-hart any-pending flag; stall_cnt out CNT_W, saturating count of stall cycles.

Function
REQ-008 SHALL hold a pending table of HART_NUM x 2^REG_W bits; the bit for register 0 SHALL always read 0.
REQ-009 SHALL set pending[id_hart_id][rd_addr] on the clock edge when id_issue=1, id_valid=1, gpr_we_=0 and rd_addr!=0.
REQ-010 SHALL clear pending[wb_hart_id][wb_rd_addr] on the clock edge when wb_en=1 and wb_gpr_we_=0.
REQ-011 SHALL let the set win when the set and clear of REQ-009/010 address the same hart and register in the same cycle.
REQ-012 SHALL clear all pending bits of hkill_id when hkill=1; a same-cycle set for that hart SHALL be suppressed, and sets for other harts SHALL be unaffected.
REQ-013 SHALL declare an EX match for rsN when ex_en=1, ex_gpr_we_=0, ex_hart_id=id_hart_id, ex_rd_addr=rsN and rsN!=0; a MEM match is defined the same way on the mem_* signals.
REQ-014 SHALL drive rsN_fwd_ctrl combinationally: EX if EX match, else MEM if MEM match, else NONE; EX SHALL take priority over MEM.
REQ-015 SHALL force rsN_fwd_ctrl to NONE when id_valid=0 or the corresponding src_reg_used bit is 0.
REQ-016 SHALL assert hazard_stall combinationally when id_valid=1 and, for any used source, either: the EX match holds with ex_is_load=1 (load-use), or the pending bit is set with neither an EX nor a MEM match (long-latency producer).
REQ-017 SHALL have hazard_stall independent of id_issue, so there is no combinational loop through the issue path.
REQ-018 SHALL drive pend_any[h] as the registered OR of hart h's pending row; it SHALL reflect the table one cycle after an update.
REQ-019 SHALL increment stall_cnt on each clock edge where hazard_stall=1, and SHALL saturate at all-ones without wrapping.
REQ-020 SHALL ignore an id_issue that arrives with hazard_stall=1, i.e. no set occurs.

Reset
REQ-021 SHALL, while reset=0, asynchronously clear the pending table, pend_any and stall_cnt, independent of clk.
REQ-022 SHALL drive fwd_ctrl=NONE and hazard_stall=0 while reset=0, and SHALL perform no table update on the first edge after release unless that edge's inputs request one.
REQ-023 SHALL discard all in-flight pending state when reset is asserted mid-operation; no partial state SHALL survive.

Verification
REQ-024 SHALL cover: hart 1 issues rd=5, next cycle EX shows hart1/rd5 non-load, and ID hart1 reads rs1=5 -> rs1_fwd_ctrl=01, hazard_stall=0.
REQ-025 SHALL cover: EX hart1 rd=5 load and MEM hart1 rd=5, with ID hart1 rs1=5 -> hazard_stall=1 and stall_cnt +1 per cycle; the same case with ex_is_load=0 -> rs1_fwd_ctrl=01, since EX beats MEM.
REQ-026 SHALL cover: pending[2][7] set with no EX/MEM match and ID hart2 rs2=7 used -> stall held until wb hart2 rd7 -> stall drops the following cycle; pend_any[2] goes 1->0.
REQ-027 SHALL cover: same-cycle issue and WB of hart0 rd3 -> bit remains 1; rd=0 issue -> no bit set; EX match on a different hart -> fwd_ctrl=00.
REQ-028 SHALL cover: hkill for hart 3 with 4 bits pending plus a same-cycle hart-3 issue -> pend_any[3]=0, while other harts are unchanged.
REQ-029 SHALL cover: CNT_W=4 with 20 stall cycles -> stall_cnt=15; reset pulsed low mid-stall -> all outputs at reset values immediately, without waiting for a clk edge.
